// File: rtl/demux_pkg.sv
// demux_pkg: shared sizes, invalid-select code and slot state type for demux_slot_router
package demux_pkg;
  localparam int NUM_OUT = 31;
  localparam int DATA_W = 2;
  localparam int SEL_W = 5;
  localparam int CNT_W = 8;
  localparam logic [SEL_W-1:0] INVALID_SEL = 5'd31;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;
endpackage

// File: rtl/demux_slot_router_if.sv
// demux_slot_router_if: upstream handshake, per-channel slot outputs and drop status
interface demux_slot_router_if;
  import demux_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [DATA_W-1:0] in_data;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;
  logic err_sel;
  logic [CNT_W-1:0] drop_cnt;
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input in_ready, out_data, out_valid, err_sel, drop_cnt
  );
  modport slave (
    input in_valid, in_sel, in_data, out_ready,
    output in_ready, out_data, out_valid, err_sel, drop_cnt
  );
endinterface

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding slot with valid/ready output and write strobe
module demux_slot
  import demux_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic clk,
  input  logic rst,
  input  logic wr,
  input  logic [DW-1:0] wdata,
  input  logic ready,
  output logic valid,
  output logic [DW-1:0] data
);
  slot_state_e state, state_n;
  // slot occupancy register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= SLOT_EMPTY;
    else state <= state_n;
  // a write always fills; otherwise a taken word empties the slot
  always_comb begin
    state_n = state;
    state_n = wr ? SLOT_FULL : (ready ? SLOT_EMPTY : state);
  end
  // payload only changes on write so an emptied slot keeps its last word
  always_ff @(posedge clk or posedge rst)
    if (rst) data <= '0;
    else if (wr) data <= wdata;
  assign valid = (state == SLOT_FULL);
endmodule

// File: rtl/demux_slot_router.sv
// demux_slot_router: registered 1-to-31 demultiplexer with per-channel slots and drop counting
module demux_slot_router
  import demux_pkg::*;
(
  input logic clk,
  input logic rst,
  demux_slot_router_if.slave bus
);
  logic [2**SEL_W-1:0] busy;
  logic [NUM_OUT-1:0] wr;
  logic [NUM_OUT-1:0] valid_w;
  logic [NUM_OUT*DATA_W-1:0] data_w;
  logic in_range, accept, drop;
  // a channel blocks only while full and not being drained; unused select codes never block
  always_comb begin
    busy = '0;
    busy[NUM_OUT-1:0] = valid_w & ~bus.out_ready;
  end
  assign in_range = bus.in_sel <= SEL_W'(NUM_OUT - 1);
  assign bus.in_ready = !busy[bus.in_sel];
  assign accept = bus.in_valid && bus.in_ready;
  assign drop = accept && !in_range;
  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    assign wr[g] = accept && (bus.in_sel == SEL_W'(g));
    demux_slot #(.DW(DATA_W)) u_slot (
      .clk(clk),
      .rst(rst),
      .wr(wr[g]),
      .wdata(bus.in_data),
      .ready(bus.out_ready[g]),
      .valid(valid_w[g]),
      .data(data_w[g*DATA_W +: DATA_W])
    );
  end
  assign bus.out_valid = valid_w;
  assign bus.out_data = data_w;
  // error pulse and saturating drop count for consumed out-of-range words
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.err_sel <= 1'b0;
      bus.drop_cnt <= '0;
    end else begin
      bus.err_sel <= drop;
      if (drop && bus.drop_cnt != '1) bus.drop_cnt <= bus.drop_cnt + 1'b1;
    end
endmodule

// File: tb/tb_demux_slot_router.sv
// tb_demux_slot_router: directed and random checks against a behavioural slot model
module tb_demux_slot_router;
  import demux_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  demux_slot_router_if bus();
  demux_slot_router dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int checks = 0;
  int failures = 0;
  logic run = 1'b1;
  logic [NUM_OUT-1:0] mv;
  logic [DATA_W-1:0] md [NUM_OUT];
  logic merr;
  int mcnt;
  logic m_ready, m_acc, m_bad;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [NUM_OUT*DATA_W-1:0] flat();
    logic [NUM_OUT*DATA_W-1:0] f;
    for (int k = 0; k < NUM_OUT; k++) f[k*DATA_W +: DATA_W] = md[k];
    return f;
  endfunction
  always_comb begin
    m_bad = int'(bus.in_sel) >= NUM_OUT;
    m_ready = m_bad ? 1'b1 : (!mv[bus.in_sel] || bus.out_ready[bus.in_sel]);
    m_acc = bus.in_valid && m_ready;
  end
  always @(posedge clk or posedge rst)
    if (rst) begin
      mv <= '0;
      for (int k = 0; k < NUM_OUT; k++) md[k] <= '0;
      merr <= 1'b0;
      mcnt <= 0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++)
        if (m_acc && int'(bus.in_sel) == k) begin
          mv[k] <= 1'b1;
          md[k] <= bus.in_data;
        end else if (bus.out_ready[k]) mv[k] <= 1'b0;
      merr <= m_acc && m_bad;
      if (m_acc && m_bad && mcnt < (1 << CNT_W) - 1) mcnt <= mcnt + 1;
    end
  always @(negedge clk)
    if (run) begin
      chk("cmp_in_ready", 64'(bus.in_ready), 64'(m_ready));
      chk("cmp_out_valid", 64'(bus.out_valid), 64'(mv));
      chk("cmp_out_data", 64'(bus.out_data), 64'(flat()));
      chk("cmp_err_sel", 64'(bus.err_sel), 64'(merr));
      chk("cmp_drop_cnt", 64'(bus.drop_cnt), 64'(mcnt));
    end
  task automatic drive(input logic v, input int sel, input int d, input logic [NUM_OUT-1:0] r);
    bus.in_valid = v;
    bus.in_sel = sel[SEL_W-1:0];
    bus.in_data = d[DATA_W-1:0];
    bus.out_ready = r;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(0, 0, 0, '0);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    step();
    rst = 1'b0;
    drive(1, 5, 2, '0);
    step();
    drive(0, 0, 0, '0);
    @(negedge clk);
    chk("t1_valid", 64'(bus.out_valid), 64'h20);
    chk("t1_data", 64'(bus.out_data[11:10]), 64'd2);
    step();
    drive(1, 5, 1, '0);
    #1 chk("t2_ready_blocked", 64'(bus.in_ready), 64'd0);
    step();
    drive(1, 6, 3, '0);
    #1 chk("t2_ready_other", 64'(bus.in_ready), 64'd1);
    step();
    drive(0, 0, 0, '0);
    @(negedge clk);
    chk("t2_keep5", 64'(bus.out_data[11:10]), 64'd2);
    chk("t2_valid6", 64'(bus.out_valid[6]), 64'd1);
    step();
    drive(1, 3, 1, '0);
    step();
    drive(1, 3, 3, 31'h8);
    #1 chk("t3_ready", 64'(bus.in_ready), 64'd1);
    step();
    drive(0, 0, 0, '0);
    @(negedge clk);
    chk("t3_valid3", 64'(bus.out_valid[3]), 64'd1);
    chk("t3_data3", 64'(bus.out_data[7:6]), 64'd3);
    drive(0, 0, 0, '1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, '0);
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 31, i, '0);
      #1 chk("t4_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      chk("t4_err", 64'(bus.err_sel), 64'd1);
      chk("t4_cnt", 64'(bus.drop_cnt), 64'(i + 1));
    end
    drive(0, 0, 0, '0);
    @(posedge clk);
    @(negedge clk);
    chk("t4_err_low", 64'(bus.err_sel), 64'd0);
    chk("t4_cnt3", 64'(bus.drop_cnt), 64'd3);
    chk("t4_no_valid", 64'(bus.out_valid), 64'd0);
    drive(1, 31, 0, '0);
    repeat (257) @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, '0);
    chk("t4_sat", 64'(bus.drop_cnt), 64'd255);
    for (int k = 0; k < NUM_OUT; k++) begin
      drive(1, k, k + 1, '1);
      @(posedge clk);
      @(negedge clk);
      chk("t5_valid", 64'(bus.out_valid), 64'd1 << k);
      chk("t5_data", 64'(bus.out_data[k*DATA_W +: DATA_W]), 64'((k + 1) % 4));
    end
    drive(0, 0, 0, '1);
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 1, '0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 15, 2, '0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 30, 3, '0);
    @(posedge clk);
    @(negedge clk);
    chk("t6_filled", 64'(bus.out_valid), 64'h4000_8001);
    drive(1, 20, 1, '0);
    step();
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_rst_data", 64'(bus.out_data), 64'd0);
    chk("t6_rst_cnt", 64'(bus.drop_cnt), 64'd0);
    chk("t6_rst_err", 64'(bus.err_sel), 64'd0);
    step();
    rst = 1'b0;
    drive(1, 7, 3, '0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, '0);
    chk("t6_after_valid", 64'(bus.out_valid), 64'h80);
    chk("t6_after_data", 64'(bus.out_data[15:14]), 64'd3);
    repeat (3000) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 3),
            ($urandom_range(0, 1) != 0) ? NUM_OUT'($urandom) : NUM_OUT'($urandom & $urandom));
    end
    step();
    rst = 1'b0;
    drive(0, 0, 0, '0);
    @(negedge clk);
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
